// File: rtl/apb_otp_frontend.sv
// APB3 front-end for the one-time-pad store: stages 32-bit writes into wide pad entries and
// serves each committed entry exactly once, zeroizing it after its last word is read.
module apb_otp_frontend #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel,
  input  logic             penable,
  input  logic             pwrite,
  input  logic [11:0]      paddr,
  input  logic [31:0]      pwdata,
  output logic [31:0]      prdata,
  output logic             pready,
  output logic             pslverr,
  output logic [31:0]      pad_addr,
  output logic [WIDTH-1:0] pad_wdata,
  output logic             pad_we,
  input  logic [WIDTH-1:0] pad_rdata
);

  localparam int unsigned NWORDS = WIDTH / 32;

  typedef enum logic [2:0] {StIdle, StCommit, StFetch, StZeroize, StResp} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] stage_q;
  logic [7:0]       idx_q;
  logic [255:0]     valid_q;
  logic [255:0]     used_q;
  logic             lock_q;
  logic [8:0]       vcount_q;
  logic             last_q;

  logic [31:0] word_ext;
  logic        word_ok, is_ctrl, is_status, is_idx, is_stage, is_read;
  logic        entry_ok, err, last_word;
  logic [31:0] stage_word, pad_word, rd_val;
  logic        unused_paddr;

  assign unused_paddr = ^paddr[1:0];
  assign word_ext     = {29'b0, paddr[4:2]};
  assign word_ok      = !paddr[5] && (word_ext < NWORDS);
  assign is_ctrl      = (paddr[11:2] == 10'd0);
  assign is_status    = (paddr[11:2] == 10'd1);
  assign is_idx       = (paddr[11:2] == 10'd2);
  assign is_stage     = (paddr[11:6] == 6'h01) && word_ok;
  assign is_read      = (paddr[11:6] == 6'h02) && word_ok;
  assign entry_ok     = valid_q[idx_q] && !used_q[idx_q];
  assign last_word    = (word_ext == NWORDS - 1);
  assign pad_addr     = {24'b0, idx_q};
  assign pready       = psel && penable && ((state_q == StIdle) || (state_q == StResp));

  always_comb begin
    stage_word = '0;
    pad_word   = '0;
    for (int unsigned i = 0; i < NWORDS; i++) begin
      if (word_ext == i) begin
        stage_word = stage_q[32*i +: 32];
        pad_word   = pad_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    err = !(is_ctrl || is_status || is_idx || is_stage || is_read);
    if (pwrite && (is_status || is_read)) err = 1'b1;
    if (pwrite && is_ctrl && pwdata[0] && lock_q) err = 1'b1;
    if (pwrite && is_stage && lock_q) err = 1'b1;
    if (!pwrite && is_read && !entry_ok) err = 1'b1;
  end

  always_comb begin
    rd_val = '0;
    if (!pwrite) begin
      if (is_status) begin
        rd_val = {15'b0, vcount_q, 4'b0, used_q[idx_q], valid_q[idx_q], lock_q, 1'b0};
      end else if (is_idx) begin
        rd_val = {24'b0, idx_q};
      end else if (is_stage) begin
        rd_val = stage_word;
      end
    end
  end

  // Every access is decoded on its setup edge so that plain accesses have their response
  // registered by the first access cycle, and waited ones are already in their first wait state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      prdata    <= '0;
      pslverr   <= 1'b0;
      pad_we    <= 1'b0;
      pad_wdata <= '0;
      stage_q   <= '0;
      idx_q     <= '0;
      valid_q   <= '0;
      used_q    <= '0;
      lock_q    <= 1'b0;
      vcount_q  <= '0;
      last_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (psel && !penable) begin
            prdata  <= err ? 32'h0 : rd_val;
            pslverr <= err;
            if (!err && pwrite) begin
              // Commit sees the old lock; a LOCK bit in the same write applies afterwards.
              if (is_ctrl && pwdata[0]) begin
                state_q   <= StCommit;
                pad_we    <= 1'b1;
                pad_wdata <= stage_q;
              end
              if (is_ctrl && pwdata[1]) lock_q <= 1'b1;
              if (is_idx) idx_q <= pwdata[7:0];
              if (is_stage) begin
                for (int unsigned i = 0; i < NWORDS; i++) begin
                  if (word_ext == i) stage_q[32*i +: 32] <= pwdata;
                end
              end
            end else if (!err && is_read) begin
              state_q <= StFetch;
              prdata  <= pad_word;
              last_q  <= last_word;
            end
          end
        end
        StCommit: begin
          pad_we         <= 1'b0;
          valid_q[idx_q] <= 1'b1;
          used_q[idx_q]  <= 1'b0;
          stage_q        <= '0;
          if (!valid_q[idx_q] && (vcount_q != 9'd256)) vcount_q <= vcount_q + 9'd1;
          state_q        <= StResp;
        end
        StFetch: begin
          if (last_q) begin
            pad_we    <= 1'b1;
            pad_wdata <= '0;
            state_q   <= StZeroize;
          end else begin
            state_q <= StResp;
          end
        end
        StZeroize: begin
          pad_we         <= 1'b0;
          used_q[idx_q]  <= 1'b1;
          valid_q[idx_q] <= 1'b0;
          if (vcount_q != 9'd0) vcount_q <= vcount_q - 9'd1;
          state_q        <= StResp;
        end
        StResp: begin
          pslverr <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The count can only move with a valid-bit transition, so it never leaves 0..256.
  vcount_bound: assert property (@(posedge clk) disable iff (rst) vcount_q <= 9'd256);

endmodule

// File: tb/tb_apb_otp_frontend.sv
// Directed bench for apb_otp_frontend with a behavioural pad memory and pad_we monitor.
module tb_apb_otp_frontend;
  localparam int unsigned WIDTH = 128;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]      paddr = '0;
  logic [31:0]      pwdata = '0;
  logic [31:0]      prdata;
  logic             pready, pslverr;
  logic [31:0]      pad_addr;
  logic [WIDTH-1:0] pad_wdata;
  logic             pad_we;
  logic [WIDTH-1:0] pad_rdata;

  always #5 clk = ~clk;

  apb_otp_frontend #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .pad_addr(pad_addr), .pad_wdata(pad_wdata), .pad_we(pad_we), .pad_rdata(pad_rdata)
  );

  logic [WIDTH-1:0] mem [256];
  always @(posedge clk) if (pad_we) mem[pad_addr[7:0]] <= pad_wdata;
  assign pad_rdata = mem[pad_addr[7:0]];

  int               n_cmp = 0, n_fail = 0;
  int               we_count = 0, we_run = 0, we0;
  logic             prev_we = 1'b0;
  logic [31:0]      we_addr = '0;
  logic [WIDTH-1:0] we_data = '0;

  always @(posedge clk) begin
    if (pad_we) begin
      we_count <= we_count + 1;
      we_addr  <= pad_addr;
      we_data  <= pad_wdata;
      if (prev_we) we_run <= we_run + 1;
    end
    prev_we <= pad_we;
  end

  logic [31:0] rd;
  logic        err;
  int          w;

  task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     output logic [31:0] rdata, output logic perr, output int waits);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; rdata = '0; perr = 1'b0;
    while (1) begin
      @(negedge clk);
      if (pready) begin
        rdata = prdata; perr = pslverr;
        break;
      end
      waits++;
      if (waits > 20) begin
        n_cmp++; n_fail++;
        $display("FAIL apb_timeout: addr %h got no pready, want pready within 20 cycles", a);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (pad_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b want 0", pad_we); end
    end
    n_cmp++; if (pad_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", pad_addr); end
    @(posedge clk); #1 rst = 1'b0;
    apb(1'b0, 12'h004, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0", rd); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (w !== 0) begin n_fail++; $display("FAIL rst_wait: got %0d want 0", w); end
  endtask

  task automatic test_commit();
    logic [11:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 12'h040 + 12'(4 * i);
      apb(1'b1, a, 32'h11111111 * (i + 1), rd, err, w);
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL stage_wr%0d: got err %b want 0", i, err); end
    end
    apb(1'b1, 12'h008, 32'd5, rd, err, w);
    we0 = we_count;
    apb(1'b1, 12'h000, 32'h1, rd, err, w);
    n_cmp++; if (w !== 1) begin n_fail++; $display("FAIL commit_wait: got %0d want 1", w); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL commit_err: got %b want 0", err); end
    n_cmp++; if (we_count - we0 !== 1) begin n_fail++; $display("FAIL commit_pulses: got %0d want 1", we_count - we0); end
    n_cmp++; if (we_addr !== 32'd5) begin n_fail++; $display("FAIL commit_addr: got %h want 5", we_addr); end
    n_cmp++; if (we_data !== 128'h44444444_33333333_22222222_11111111) begin
      n_fail++; $display("FAIL commit_data: got %h want 44444444333333332222222211111111", we_data);
    end
    apb(1'b0, 12'h004, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0000_0104) begin n_fail++; $display("FAIL commit_status: got %h want 00000104", rd); end
    apb(1'b0, 12'h040, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL stage_cleared: got %h want 0", rd); end
  endtask

  task automatic test_read_once();
    logic [11:0] a;
    we0 = we_count;
    for (int i = 0; i < 4; i++) begin
      a = 12'h080 + 12'(4 * i);
      apb(1'b0, a, 32'h0, rd, err, w);
      n_cmp++; if (rd !== 32'h11111111 * (i + 1)) begin
        n_fail++; $display("FAIL read%0d_data: got %h want %h", i, rd, 32'h11111111 * (i + 1));
      end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL read%0d_err: got %b want 0", i, err); end
      n_cmp++; if (w !== ((i == 3) ? 2 : 1)) begin
        n_fail++; $display("FAIL read%0d_wait: got %0d want %0d", i, w, (i == 3) ? 2 : 1);
      end
    end
    n_cmp++; if (we_count - we0 !== 1) begin n_fail++; $display("FAIL zeroize_pulses: got %0d want 1", we_count - we0); end
    n_cmp++; if (we_data !== '0) begin n_fail++; $display("FAIL zeroize_data: got %h want 0", we_data); end
    apb(1'b0, 12'h080, 32'h0, rd, err, w);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL reread_err: got %b want 1", err); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reread_data: got %h want 0", rd); end
    apb(1'b0, 12'h004, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0000_0008) begin n_fail++; $display("FAIL used_status: got %h want 00000008", rd); end
  endtask

  task automatic test_errors();
    apb(1'b0, 12'h0C0, 32'h0, rd, err, w);
    n_cmp++; if (err !== 1'b1 || w !== 0 || rd !== 32'h0) begin
      n_fail++; $display("FAIL bad_offset: got err %b wait %0d data %h want 1 0 0", err, w, rd);
    end
    apb(1'b1, 12'h004, 32'hFFFF_FFFF, rd, err, w);
    n_cmp++; if (err !== 1'b1 || w !== 0) begin
      n_fail++; $display("FAIL ro_write: got err %b wait %0d want 1 0", err, w);
    end
    apb(1'b1, 12'h008, 32'd200, rd, err, w);
    apb(1'b0, 12'h080, 32'h0, rd, err, w);
    n_cmp++; if (err !== 1'b1 || w !== 0) begin
      n_fail++; $display("FAIL uncommitted: got err %b wait %0d want 1 0", err, w);
    end
    apb(1'b0, 12'h090, 32'h0, rd, err, w);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL read_oob: got %b want 1", err); end
  endtask

  task automatic test_lock();
    apb(1'b1, 12'h000, 32'h2, rd, err, w);
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL lock_wr: got %b want 0", err); end
    we0 = we_count;
    apb(1'b1, 12'h000, 32'h1, rd, err, w);
    n_cmp++; if (err !== 1'b1 || w !== 0) begin
      n_fail++; $display("FAIL locked_commit: got err %b wait %0d want 1 0", err, w);
    end
    apb(1'b1, 12'h040, 32'hDEAD_BEEF, rd, err, w);
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL locked_stage: got %b want 1", err); end
    n_cmp++; if (we_count !== we0) begin n_fail++; $display("FAIL locked_we: got %0d want %0d", we_count, we0); end
    apb(1'b0, 12'h040, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL locked_stage_rd: got %h want 0", rd); end
    apb(1'b0, 12'h004, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0000_0002) begin n_fail++; $display("FAIL lock_status: got %h want 00000002", rd); end
  endtask

  task automatic test_rst_mid_commit();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    apb(1'b1, 12'h040, 32'hAAAA_5555, rd, err, w);
    apb(1'b1, 12'h008, 32'd7, rd, err, w);
    we0 = we_count;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    n_cmp++; if (pad_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_high: got %b want 1", pad_we); end
    rst = 1'b1;
    #1;
    n_cmp++; if (pad_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we_drop: got %b want 0", pad_we); end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    n_cmp++; if (we_count !== we0) begin n_fail++; $display("FAIL midrst_pulses: got %0d want %0d", we_count, we0); end
    apb(1'b0, 12'h004, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0 || w !== 0) begin
      n_fail++; $display("FAIL midrst_status: got %h wait %0d want 0 0", rd, w);
    end
    apb(1'b0, 12'h008, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0 || err !== 1'b0) begin
      n_fail++; $display("FAIL midrst_idx: got %h err %b want 0 0", rd, err);
    end
    apb(1'b0, 12'h040, 32'h0, rd, err, w);
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL midrst_stage: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_read_once();
    test_errors();
    test_lock();
    test_rst_mid_commit();
    n_cmp++; if (we_run !== 0) begin n_fail++; $display("FAIL we_back_to_back: got %0d want 0", we_run); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_otp_frontend.md
Name: apb_otp_frontend

Overview:
- APB3 slave front-end feeding the one-time-pad memory (pad storage: 256 entries of WIDTH bits, synchronous write, combinational read).
- Narrows 32-bit APB accesses into wide pad writes through a staging buffer.
- Enforces read-once semantics: an entry is zeroized in memory right after its last word is read.
- Keeps per-entry valid/used tracking and a sticky lock.

Parameters:
- WIDTH, 128, pad entry width; multiple of 32, range 32..256. NWORDS = WIDTH/32.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- paddr  in  12  APB byte address; bits [1:0] ignored
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error
- pad_addr  out  32  pad entry index, zero-extended from 8 bits
- pad_wdata  out  WIDTH  pad write data
- pad_we  out  1  pad write strobe, one cycle
- pad_rdata  in  WIDTH  pad read data, combinational on pad_addr

Behaviour:
- Reset values (async on rst): prdata=0, pslverr=0, pad_we=0, pad_wdata=0; staging=0, PAD_IDX=0, valid/used bitmaps=0, lock=0, vcount=0, FSM=IDLE. pad_addr = PAD_IDX, so it is 0 in reset.
- pready is combinational and 0 outside the access phase.
- Register map (byte offsets):
  - 0x000 CTRL (W): bit0 COMMIT; bit1 LOCK (sticky until rst). Reads return 0.
  - 0x004 STATUS (R): bit1 lock; bit2 valid[PAD_IDX]; bit3 used[PAD_IDX]; bits[16:8] vcount (0..256).
  - 0x008 PAD_IDX (RW, 8 bits).
  - 0x040 + 4*i STAGE[i] (RW), i < NWORDS.
  - 0x080 + 4*i READ[i] (R), i < NWORDS.
  - Any other offset, or a write to a read-only location: pslverr=1, prdata=0, zero wait, no state change.
- FSM states: IDLE, COMMIT, FETCH, ZEROIZE, RESP.
- Plain register accesses (STATUS, PAD_IDX, STAGE, CTRL without COMMIT): completed in IDLE with pready=1 in the first access cycle (zero wait).
- Commit (CTRL write, COMMIT=1, lock=0):
  - IDLE->COMMIT: pad_we=1, pad_wdata=staging, pready=0.
  - COMMIT->RESP: pready=1. Same edge: valid[idx]=1, used[idx]=0, staging cleared to 0. vcount increments only if the entry was not already valid.
  - Latency: 1 wait state.
- Commit or STAGE write while lock=1: pslverr=1, zero wait, nothing written.
- LOCK and COMMIT in the same write: COMMIT is evaluated first with the old lock, then lock is set.
- READ[i] when valid[idx]=1 and used[idx]=0:
  - IDLE->FETCH, pready=0. Capture prdata = pad_rdata[32i+:32].
  - If i != NWORDS-1: FETCH->RESP (1 wait state).
  - If i == NWORDS-1: FETCH->ZEROIZE, which drives pad_we=1 and pad_wdata=0. Then ZEROIZE->RESP (2 wait states). On the ZEROIZE edge: used[idx]=1, valid[idx]=0, vcount decrements.
- READ[i] when valid[idx]=0 or used[idx]=1: prdata=0, pslverr=1, zero wait, no pad access.
- RESP: pready=1, pslverr=0; next state IDLE.
- pad_we is asserted only in COMMIT and ZEROIZE, never for more than one consecutive cycle.
- pad_addr is stable for the whole transaction; PAD_IDX cannot change while the FSM is not IDLE.
- Master must hold psel/penable/paddr until pready. If psel drops mid-wait (protocol violation), the FSM still completes its sequence and returns to IDLE.
- rst asserted mid-COMMIT/ZEROIZE: pad_we drops immediately. A partial pad write is the memory's concern; all tracking state clears.
- vcount saturates at 0 and 256. It cannot exceed these bounds by construction; the saturation is kept as an assertion.

Test Plan:
- Reset, then read STATUS -> prdata=0x0000_0000, pslverr=0. Assert pad_we=0 throughout reset.
- WIDTH=128: write STAGE0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; PAD_IDX=5; CTRL=1 -> exactly one pad_we pulse with pad_addr=5 and pad_wdata=0x44444444_33333333_22222222_11111111. Commit shows 1 wait state. Then STATUS bits[16:8]=1, bit2=1, and STAGE0 reads 0.
- Read READ0..READ3 at idx 5 -> returns 0x11111111..0x44444444. READ0..2 each have 1 wait state; READ3 has 2 wait states followed by a pad_we pulse with wdata=0. A subsequent READ0 -> pslverr=1, prdata=0. STATUS bit3=1, vcount=0.
- Write CTRL=0x2, then CTRL=0x1 and a STAGE0 write -> both pslverr=1, no pad_we. STATUS bit1=1 until rst.
- Access 0x0C0 and write 0x004 -> pslverr=1 with zero wait. READ at an uncommitted idx 200 -> pslverr=1.
- Assert rst during the COMMIT cycle -> pad_we falls asynchronously. After release: vcount=0, PAD_IDX=0, FSM IDLE, and the next register access completes with zero wait.
